// File: rtl/hazard_unit.sv
// hazard_unit: pipeline stall/flush controller for load-use, taken-branch and multi-cycle memory hazards
module hazard_unit #(
  parameter int MEM_TIMEOUT = 255,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [4:0]             i_ID_rnum1,
  input  logic [4:0]             i_ID_rnum2,
  input  logic                   i_ID_ruse1,
  input  logic                   i_ID_ruse2,
  input  logic [4:0]             i_EX_wnum,
  input  logic                   i_EX_mem_read,
  input  logic                   i_EX_branch_taken,
  input  logic                   i_MEM_req,
  input  logic                   i_MEM_ack,
  output logic                   o_PC_en,
  output logic                   o_IFID_en,
  output logic                   o_IFID_flush,
  output logic                   o_IDEX_flush,
  output logic                   o_pipe_en,
  output logic                   o_mem_err,
  output logic [STALL_CNT_W-1:0] o_stall_cnt
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  state_t state, state_nx;
  logic [WW-1:0] wait_cnt, wait_nx;
  logic load_use, release_now, freeze;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
    end
  end
  always_comb begin
    release_now = (state == MEM_WAIT) && (i_MEM_ack || wait_cnt == WW'(MEM_TIMEOUT));
    freeze      = (state == RUN) ? (i_MEM_req && !i_MEM_ack) : !release_now;
    state_nx    = freeze ? MEM_WAIT : RUN;
    wait_nx     = !freeze ? '0 : (state == RUN) ? WW'(1) : wait_cnt + WW'(1);
  end
  always_comb begin
    load_use     = i_EX_mem_read && (i_EX_wnum != 5'd0) &&
                   ((i_ID_ruse1 && i_EX_wnum == i_ID_rnum1) || (i_ID_ruse2 && i_EX_wnum == i_ID_rnum2));
    o_PC_en      = !i_rst && !freeze && (i_EX_branch_taken || !load_use);
    o_IFID_en    = o_PC_en;
    o_pipe_en    = !i_rst && !freeze;
    o_IFID_flush = i_rst || (!freeze && i_EX_branch_taken);
    o_IDEX_flush = i_rst || (!freeze && (i_EX_branch_taken || load_use));
    o_mem_err    = !i_rst && release_now && !i_MEM_ack;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) o_stall_cnt <= '0;
    else if (!o_PC_en && !(&o_stall_cnt)) o_stall_cnt <= o_stall_cnt + 1'b1;
  end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: scoreboard bench for hazard_unit against a behavioural model
module tb_hazard_unit;
  localparam int T = 4;
  logic clk = 0, rst = 1;
  logic [4:0] r1 = 0, r2 = 0, w = 0;
  logic u1 = 0, u2 = 0, mr = 0, br = 0, req = 0, ack = 0;
  logic pc_en, ifid_en, ifid_fl, idex_fl, pipe_en, mem_err;
  logic [31:0] stall_cnt;
  typedef struct {logic [5:0] ctl; int stall; bit known;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  bit waiting = 0, known = 0;
  int frozen = 0, stall = 0;
  always #5 clk = ~clk;
  hazard_unit #(.MEM_TIMEOUT(T), .STALL_CNT_W(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_ID_rnum1(r1), .i_ID_rnum2(r2), .i_ID_ruse1(u1), .i_ID_ruse2(u2),
    .i_EX_wnum(w), .i_EX_mem_read(mr), .i_EX_branch_taken(br), .i_MEM_req(req), .i_MEM_ack(ack),
    .o_PC_en(pc_en), .o_IFID_en(ifid_en), .o_IFID_flush(ifid_fl), .o_IDEX_flush(idex_fl),
    .o_pipe_en(pipe_en), .o_mem_err(mem_err), .o_stall_cnt(stall_cnt));
  task automatic cyc(input bit rs, input int a, input int b, input bit ua, input bit ub,
                     input int wd, input bit ld, input bit bt, input bit rq, input bit ak);
    exp_t e;
    bit lu, fz, rel;
    @(posedge clk);
    #1;
    rst = rs; r1 = 5'(a); r2 = 5'(b); u1 = ua; u2 = ub; w = 5'(wd);
    mr = ld; br = bt; req = rq; ack = ak;
    lu = ld && wd != 0 && ((ua && wd == a) || (ub && wd == b));
    e.stall = stall;
    e.known = known;
    if (rs) begin
      e.ctl = 6'b001100;
      waiting = 0; frozen = 0; stall = 0; known = 1;
    end else begin
      rel = waiting && (ak || frozen == T);
      fz = waiting ? !rel : (rq && !ak);
      e.ctl = fz ? 6'b000000 : bt ? 6'b111110 : lu ? 6'b000110 : 6'b110010;
      if (rel && !ak) e.ctl[0] = 1;
      if (fz) begin
        frozen = waiting ? frozen + 1 : 1;
        waiting = 1;
      end else begin
        waiting = 0; frozen = 0;
      end
      if (!e.ctl[5]) stall++;
    end
    q.push_back(e);
  endtask
  initial begin : monitor
    exp_t e;
    logic [5:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        act = {pc_en, ifid_en, ifid_fl, idex_fl, pipe_en, mem_err};
        checks++;
        if (act !== e.ctl) begin
          errors++;
          $display("FAIL ctl t=%0t got %b expected %b (pc,ifid_en,ifid_fl,idex_fl,pipe,err)", $time, act, e.ctl);
        end
        if (e.known) begin
          checks++;
          if (stall_cnt !== 32'(e.stall)) begin
            errors++;
            $display("FAIL stall_cnt t=%0t got %0d expected %0d", $time, stall_cnt, e.stall);
          end
        end
      end
    end
  end
  initial begin
    int n;
    cyc(1,0,0,0,0,0,0,0,0,0);
    cyc(1,0,0,0,0,0,0,0,0,0);
    cyc(0,1,5,1,1,5,1,0,0,0);
    cyc(0,1,5,1,1,0,0,0,0,0);
    cyc(0,1,5,1,0,5,1,0,0,0);
    cyc(0,0,0,1,1,0,1,0,0,0);
    cyc(0,1,5,1,1,5,1,1,0,0);
    cyc(0,0,0,0,0,0,0,0,1,0);
    cyc(0,0,0,0,0,0,0,0,1,0);
    cyc(0,0,0,0,0,0,0,0,1,0);
    cyc(0,0,0,0,0,0,0,0,1,1);
    cyc(0,0,0,0,0,0,0,0,0,0);
    for (int i = 0; i < T; i++) cyc(0,3,0,1,0,3,1,0,1,0);
    cyc(0,3,0,1,0,3,1,0,1,0);
    cyc(0,3,0,1,0,0,0,0,0,0);
    cyc(0,0,0,0,0,0,0,0,1,0);
    cyc(0,0,0,0,0,0,0,0,1,0);
    cyc(1,0,0,0,0,0,0,0,1,0);
    cyc(0,0,0,0,0,0,0,0,1,1);
    cyc(0,0,0,0,0,0,0,0,0,0);
    cyc(0,0,0,0,0,0,0,0,1,1);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0,99) == 0, $urandom_range(0,7), $urandom_range(0,7),
          1'($urandom), 1'($urandom), $urandom_range(0,7), $urandom_range(0,2) == 0,
          $urandom_range(0,5) == 0, $urandom_range(0,2) != 0, $urandom_range(0,4) == 0);
    n = 0;
    while (q.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline stall and flush controller. It covers the hazards that operand forwarding cannot resolve: load-use dependencies, taken branches and jumps resolved in EX, and multi-cycle data-memory accesses. It drives the PC and pipeline-register enables and flushes. It also keeps a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- MEM_TIMEOUT, 255: maximum number of frozen cycles spent waiting for i_MEM_ack before a forced release.
- STALL_CNT_W, 32: width of o_stall_cnt.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_ID_rnum1, i_ID_rnum2  in  reg_t (5)  source registers of the instruction in ID.
- i_ID_ruse1, i_ID_ruse2  in  1  the ID instruction actually reads rnum1 / rnum2.
- i_EX_wnum  in  reg_t  destination register of the instruction in EX.
- i_EX_mem_read  in  1  the EX instruction is a load.
- i_EX_branch_taken  in  1  a branch or jump resolved taken in EX.
- i_MEM_req  in  1  the MEM stage has an active data-memory access.
- i_MEM_ack  in  1  data memory completes the access this cycle.
- o_PC_en  out  1  PC update enable.
- o_IFID_en  out  1  IF/ID register enable.
- o_IFID_flush  out  1  load a NOP into IF/ID.
- o_IDEX_flush  out  1  load a bubble into ID/EX.
- o_pipe_en  out  1  enable for ID/EX, EX/MEM and MEM/WB.
- o_mem_err  out  1  one-cycle pulse when a memory access is released by timeout.
- o_stall_cnt  out  STALL_CNT_W  count of cycles with o_PC_en = 0.

## Operation
- The FSM has two states: RUN and MEM_WAIT. A wait counter wait_cnt counts frozen cycles and saturates at MEM_TIMEOUT.
- load_use = i_EX_mem_read & (i_EX_wnum != 0) & ((i_ID_ruse1 & i_EX_wnum == i_ID_rnum1) | (i_ID_ruse2 & i_EX_wnum == i_ID_rnum2)).
- Default outputs: all enables = 1, all flushes = 0, o_mem_err = 0.
- **Freeze** (RUN with i_MEM_req & !i_MEM_ack, or any MEM_WAIT cycle that is not a release):
  - All enables = 0 and all flushes = 0.
  - Branch and load-use are ignored; they stay stable because the pipeline is frozen.
- **Entering MEM_WAIT** from RUN sets wait_cnt = 1.
- **In MEM_WAIT without release**, wait_cnt increments.
- **Release cycle** happens in MEM_WAIT when i_MEM_ack = 1 or wait_cnt == MEM_TIMEOUT.
  - Next state is RUN.
  - o_mem_err = 1 only if the release is a timeout without an ack.
  - Branch and load-use rules are evaluated as in RUN during this cycle. A new freeze cannot start in the release cycle.
- **Branch flush** (i_EX_branch_taken, not frozen):
  - o_IFID_flush = 1 and o_IDEX_flush = 1.
  - All enables = 1, so the PC loads the target.
  - Branch takes priority over load_use.
- **Load-use stall** (load_use, no branch, not frozen):
  - o_PC_en = 0, o_IFID_en = 0, o_IDEX_flush = 1, o_pipe_en = 1.
  - Exactly one bubble is inserted. In the next cycle the load has moved to MEM, so load_use drops and forwarding supplies the operand.
- **Priority**: freeze > branch > load-use > default.
- **Stall counter**: o_stall_cnt increments in every non-reset cycle with o_PC_en = 0 and saturates at 2^STALL_CNT_W − 1.

## Timing
- **During reset**:
  - Enables are 0, o_IFID_flush = 1, o_IDEX_flush = 1, o_mem_err = 0.
  - The next state is RUN, with wait_cnt = 0 and o_stall_cnt = 0.
  - Reset during MEM_WAIT abandons the wait.
- **Combinational paths**: all control outputs are combinational from the current state, wait_cnt and inputs. There is zero-cycle latency from a hazard input to the response. o_stall_cnt is registered.
- **Ack in the same cycle as the first req**: no freeze.
- **Ack N cycles after the first req cycle** (N ≤ MEM_TIMEOUT): exactly N frozen cycles, and the ack cycle advances the pipeline.
- **No ack**: exactly MEM_TIMEOUT frozen cycles, then the release cycle with o_mem_err = 1.
- **Register x0**: never causes a load-use stall.

## Test plan
- **Load-use**: EX load x5, ID add reads x5 on rs2 with ruse2 = 1 → one cycle of PC_en = 0, IFID_en = 0, IDEX_flush = 1; the next cycle is all-enable; o_stall_cnt = 1.
- **No false stall**: the same test with ruse2 = 0, or with i_EX_wnum = 0 → no stall.
- **Branch over load-use**: branch_taken and load_use in the same cycle → both flushes = 1, PC_en = 1, o_stall_cnt unchanged.
- **Memory wait**: req held with ack arriving 3 cycles after the first req cycle → 3 frozen cycles (all enables 0), an advancing cycle on ack, o_stall_cnt += 3, o_mem_err = 0.
- **Timeout**: MEM_TIMEOUT = 4, req with no ack → 4 frozen cycles, then a release with a single o_mem_err pulse; a load_use during the freeze is applied only in the release cycle.
- **Reset mid-wait**: i_rst asserted in the 2nd MEM_WAIT cycle → reset values during reset; afterwards in RUN with o_stall_cnt = 0, and a new req with an immediate ack does not stall.
